vga_timing_gen: RTL and testbench

Raster timing generator that drives the scan position and blanking inputs of every sprite/background renderer in the display path. It produces DrawX/DrawY, the display-active flag `blank`, and the hs/vs sync pulses for the monitor. Defaults are 640x480@60 Hz from a 25 MHz pixel clock. Sync outputs are delayed to line up with the renderers' one-cycle registered colour output.

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_sync_delay.sv | 33 +++
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing defaults and position type for the display path.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam int unsigned POS_W    = 10;

  typedef logic [POS_W-1:0] pos_t;

endpackage

// File: rtl/vga_sync_delay.sv
// DEPTH-stage shift register for {hs,vs}; idles high, pass-through at DEPTH 0.
module vga_sync_delay #(
  parameter int unsigned DEPTH = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sync_in,
  output logic [1:0] sync_out
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = &{1'b0, clk, reset};
      assign sync_out    = sync_in;
    end else begin : g_pipe
      logic [1:0] stage [DEPTH];

      // Shift sync levels down the pipe; reset flushes every stage to inactive.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '1;
        end else begin
          stage[0] <= sync_in;
          for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign sync_out = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: scan position, active-video flag, sync pulses,
// line/frame strobes and a frame counter, all registered.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP       = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP       = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP       = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP       = vga_timing_pkg::V_BP,
  parameter int unsigned SYNC_DELAY = 1,
  parameter int unsigned FC_W       = 8
) (
  input  logic            vga_clk,
  input  logic            reset,
  output logic [9:0]      DrawX,
  output logic [9:0]      DrawY,
  output logic            blank,
  output logic            hs,
  output logic            vs,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count
);

  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam pos_t H_LAST = pos_t'(HT - 1);
  localparam pos_t V_LAST = pos_t'(VT - 1);
  localparam pos_t H_ACT  = pos_t'(H_ACTIVE);
  localparam pos_t V_ACT  = pos_t'(V_ACTIVE);
  localparam pos_t HS_S   = pos_t'(H_ACTIVE + H_FP);
  localparam pos_t HS_E   = pos_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam pos_t VS_S   = pos_t'(V_ACTIVE + V_FP);
  localparam pos_t VS_E   = pos_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam pos_t ONE    = pos_t'(1);
  localparam logic [FC_W-1:0] FC_ONE = FC_W'(1);

  if (HT > 1024) begin : g_bad_h
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (VT > 1024) begin : g_bad_v
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (SYNC_DELAY > 3) begin : g_bad_d
    $error("vga_timing_gen: SYNC_DELAY must be 0..3");
  end

  pos_t hc, vc, hc_next, vc_next;
  logic blank_next, ls_next, fs_next, hsr_next, vsr_next;
  logic hs_raw, vs_raw;
  logic [1:0] sync_d;

  // Next position and its decode; registering the decode together with the
  // counters keeps every flag aligned with DrawX/DrawY.
  always_comb begin
    hc_next = hc + ONE;
    vc_next = vc;
    if (hc == H_LAST) begin
      hc_next = '0;
      vc_next = (vc == V_LAST) ? pos_t'(0) : vc + ONE;
    end
    blank_next = (hc_next < H_ACT) && (vc_next < V_ACT);
    ls_next    = (hc_next == '0);
    fs_next    = (hc_next == '0) && (vc_next == '0);
    hsr_next   = !((hc_next >= HS_S) && (hc_next < HS_E));
    vsr_next   = !((vc_next >= VS_S) && (vc_next < VS_E));
  end

  // Position counters and registered decode; reset parks at the last pixel.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc          <= H_LAST;
      vc          <= V_LAST;
      blank       <= 1'b0;
      hs_raw      <= 1'b1;
      vs_raw      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      hc          <= hc_next;
      vc          <= vc_next;
      blank       <= blank_next;
      hs_raw      <= hsr_next;
      vs_raw      <= vsr_next;
      line_start  <= ls_next;
      frame_start <= fs_next;
      if (fs_next) frame_count <= frame_count + FC_ONE;
    end
  end

  vga_sync_delay #(
    .DEPTH (SYNC_DELAY)
  ) u_sync_delay (
    .clk      (vga_clk),
    .reset    (reset),
    .sync_in  ({hs_raw, vs_raw}),
    .sync_out (sync_d)
  );

  assign hs    = sync_d[1];
  assign vs    = sync_d[0];
  assign DrawX = hc;
  assign DrawY = vc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced 25x15 raster:
// instance a has SYNC_DELAY=1/FC_W=8, instance b has SYNC_DELAY=0/FC_W=2.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] xa, ya, xb, yb;
  logic       bla, blb, hsa, vsa, hsb, vsb, lsa, lsb, fsa, fsb;
  logic [7:0] fca;
  logic [1:0] fcb;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_DELAY(1), .FC_W(8)
  ) u_a (
    .vga_clk(clk), .reset(reset), .DrawX(xa), .DrawY(ya), .blank(bla),
    .hs(hsa), .vs(vsa), .line_start(lsa), .frame_start(fsa), .frame_count(fca)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_DELAY(0), .FC_W(2)
  ) u_b (
    .vga_clk(clk), .reset(reset), .DrawX(xb), .DrawY(yb), .blank(blb),
    .hs(hsb), .vs(vsb), .line_start(lsb), .frame_start(fsb), .frame_count(fcb)
  );

  typedef struct {
    int unsigned wait_n;
    int unsigned x, y;
    bit bl, hs_a, vs_a, hs_b, vs_b, ls, fs;
    int unsigned fc;
  } vec_t;

  vec_t tbl [17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag, input int unsigned fc_exp);
    chk({tag, "_xa"}, xa, 24);   chk({tag, "_ya"}, ya, 14);
    chk({tag, "_xb"}, xb, 24);   chk({tag, "_yb"}, yb, 14);
    chk({tag, "_bl"}, bla, 0);   chk({tag, "_ls"}, lsa, 0);
    chk({tag, "_fs"}, fsa, 0);
    chk({tag, "_hsa"}, hsa, 1);  chk({tag, "_vsa"}, vsa, 1);
    chk({tag, "_hsb"}, hsb, 1);  chk({tag, "_vsb"}, vsb, 1);
    chk({tag, "_fca"}, fca, fc_exp);
    chk({tag, "_fcb"}, fcb, fc_exp % 4);
  endtask

  initial begin
    int unsigned cnt, nbl, nls, hla, vla, hlb, vlb, since, bad_int, bad_y;
    logic [9:0] px, py;
    bit found;

    //          wait  x   y  bl hsa vsa hsb vsb ls fs fc
    tbl[0]  = '{1,    0,  0, 1, 1,  1,  1,  1,  1, 1, 1};
    tbl[1]  = '{1,    1,  0, 1, 1,  1,  1,  1,  0, 0, 1};
    tbl[2]  = '{14,   15, 0, 1, 1,  1,  1,  1,  0, 0, 1};
    tbl[3]  = '{1,    16, 0, 0, 1,  1,  1,  1,  0, 0, 1};
    tbl[4]  = '{2,    18, 0, 0, 1,  1,  0,  1,  0, 0, 1};
    tbl[5]  = '{1,    19, 0, 0, 0,  1,  0,  1,  0, 0, 1};
    tbl[6]  = '{3,    22, 0, 0, 0,  1,  1,  1,  0, 0, 1};
    tbl[7]  = '{1,    23, 0, 0, 1,  1,  1,  1,  0, 0, 1};
    tbl[8]  = '{1,    24, 0, 0, 1,  1,  1,  1,  0, 0, 1};
    tbl[9]  = '{1,    0,  1, 1, 1,  1,  1,  1,  1, 0, 1};
    tbl[10] = '{175,  0,  8, 0, 1,  1,  1,  1,  1, 0, 1};
    tbl[11] = '{50,   0, 10, 0, 1,  1,  1,  0,  1, 0, 1};
    tbl[12] = '{1,    1, 10, 0, 1,  0,  1,  0,  0, 0, 1};
    tbl[13] = '{49,   0, 12, 0, 1,  0,  1,  1,  1, 0, 1};
    tbl[14] = '{1,    1, 12, 0, 1,  1,  1,  1,  0, 0, 1};
    tbl[15] = '{73,  24, 14, 0, 1,  1,  1,  1,  0, 0, 1};
    tbl[16] = '{1,    0,  0, 1, 1,  1,  1,  1,  1, 1, 2};

    // Reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle($sformatf("rst%0d", i), 0);
    end
    reset = 1'b0;

    // Table-driven walk through the first frame
    for (int i = 0; i < 17; i++) begin
      repeat (tbl[i].wait_n) tick();
      chk($sformatf("v%0d_xa", i), xa, tbl[i].x);
      chk($sformatf("v%0d_ya", i), ya, tbl[i].y);
      chk($sformatf("v%0d_xb", i), xb, tbl[i].x);
      chk($sformatf("v%0d_yb", i), yb, tbl[i].y);
      chk($sformatf("v%0d_bla", i), bla, tbl[i].bl);
      chk($sformatf("v%0d_blb", i), blb, tbl[i].bl);
      chk($sformatf("v%0d_hsa", i), hsa, tbl[i].hs_a);
      chk($sformatf("v%0d_vsa", i), vsa, tbl[i].vs_a);
      chk($sformatf("v%0d_hsb", i), hsb, tbl[i].hs_b);
      chk($sformatf("v%0d_vsb", i), vsb, tbl[i].vs_b);
      chk($sformatf("v%0d_ls", i), lsa, tbl[i].ls);
      chk($sformatf("v%0d_lsb", i), lsb, tbl[i].ls);
      chk($sformatf("v%0d_fs", i), fsa, tbl[i].fs);
      chk($sformatf("v%0d_fsb", i), fsb, tbl[i].fs);
      chk($sformatf("v%0d_fca", i), fca, tbl[i].fc);
      chk($sformatf("v%0d_fcb", i), fcb, tbl[i].fc % 4);
    end

    // Whole-frame statistics, starting on the frame_start cycle
    cnt = 0; nbl = 0; nls = 0; hla = 0; vla = 0; hlb = 0; vlb = 0;
    since = 0; bad_int = 0; bad_y = 0;
    do begin
      if (bla) nbl++;
      if (lsa) begin
        nls++;
        if (cnt != 0 && since != 25) bad_int++;
        since = 0;
      end
      if (!hsa) hla++;
      if (!vsa) vla++;
      if (!hsb) hlb++;
      if (!vsb) vlb++;
      px = xa; py = ya;
      tick();
      cnt++; since++;
      if (ya != py && !(px == 24 && xa == 0)) bad_y++;
    end while (!fsa && cnt < 1000);
    chk("frame_len", cnt, 375);
    chk("blank_cycles", nbl, 128);
    chk("line_starts", nls, 15);
    chk("line_interval_bad", bad_int, 0);
    chk("y_step_bad", bad_y, 0);
    chk("hs_low_a", hla, 60);
    chk("vs_low_a", vla, 50);
    chk("hs_low_b", hlb, 60);
    chk("vs_low_b", vlb, 50);
    chk("fc3_a", fca, 3);
    chk("fc3_b", fcb, 3);

    // Narrow counter wraps 3 -> 0 -> 1
    for (int k = 0; k < 2; k++) begin
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (!fsa && cnt < 1000);
      chk($sformatf("fwrap%0d_len", k), cnt, 375);
      chk($sformatf("fwrap%0d_fca", k), fca, 4 + k);
      chk($sformatf("fwrap%0d_fcb", k), fcb, k);
    end

    // Reset pulse while inside both sync pulses
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick();
      if (xa == 20 && ya == 11) found = 1;
    end
    chk("find_pos", found, 1);
    chk("pre_hsa", hsa, 0);
    chk("pre_vsa", vsa, 0);
    chk("pre_hsb", hsb, 0);
    chk("pre_vsb", vsb, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("midrst", 0);
    tick();
    chk("post_xa", xa, 0);
    chk("post_ya", ya, 0);
    chk("post_fs", fsa, 1);
    chk("post_ls", lsa, 1);
    chk("post_bl", bla, 1);
    chk("post_fca", fca, 1);
    chk("post_fcb", fcb, 1);
    chk("post_hsa", hsa, 1);
    chk("post_vsa", vsa, 1);
    tick();
    chk("post2_xa", xa, 1);
    chk("post2_hsa", hsa, 1);
    chk("post2_fs", fsa, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
